// File: rtl/bubbledrive8_pwrmon.sv
// rtl/bubbledrive8_pwrmon.sv - power-status pin synchroniser and debouncer
// Two independent channels (0 = PWRSTAT, 1 = MRST) share the status, strobe and glitch outputs.
module bubbledrive8_pwrmon #(
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int CNT_WIDTH       = 19
) (
  input  logic       MCLK,
  input  logic       nRST,
  input  logic       PWRSTAT_RAW,
  input  logic       MRST_RAW,
  output logic       PWRSTAT,
  output logic       MRST,
  output logic       nSTABLE,
  output logic       nCHANGE,
  output logic [7:0] GLITCHCNT
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_COUNT} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e               state_q [2];
  state_e               state_d [2];
  logic [CNT_WIDTH-1:0] cnt_q   [2];
  logic [CNT_WIDTH-1:0] cnt_d   [2];
  logic [1:0]           raw;
  logic [1:0]           s1_q;
  logic [1:0]           s2_q;
  logic [1:0]           prev_q;
  logic [1:0]           out_q;
  logic [1:0]           out_d;
  logic [1:0]           settled_q;
  logic [1:0]           settled_d;
  logic [1:0]           chg;
  logic [1:0]           glt;
  logic                 nstable_q;
  logic                 nstable_d;
  logic                 nchange_q;
  logic                 nchange_d;
  logic [7:0]           glitch_q;
  logic [7:0]           glitch_d;
  logic [8:0]           glitch_sum;

  assign raw = {MRST_RAW, PWRSTAT_RAW};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      out_d[i]     = out_q[i];
      settled_d[i] = settled_q[i];
      chg[i]       = 1'b0;
      glt[i]       = 1'b0;
      case (state_q[i])
        ST_INIT: begin
          // Initial acquisition needs a run of identical samples, not agreement with the output.
          if (s2_q[i] == prev_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
              out_d[i]     = s2_q[i];
              settled_d[i] = 1'b1;
              state_d[i]   = ST_IDLE;
              cnt_d[i]     = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end else begin
            cnt_d[i] = CNT_ONE;
          end
        end
        ST_IDLE: begin
          if (s2_q[i] != out_q[i]) begin
            state_d[i] = ST_COUNT;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ST_COUNT: begin
          if (s2_q[i] == out_q[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
            glt[i]     = 1'b1;
          end else if (cnt_q[i] == CNT_LAST) begin
            out_d[i]   = s2_q[i];
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
            chg[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_INIT;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    glitch_sum = {1'b0, glitch_q} + {8'd0, glt[0]} + {8'd0, glt[1]};
    glitch_d   = (glitch_sum > 9'd255) ? 8'hFF : glitch_sum[7:0];
    nstable_d  = nstable_q & ~(&settled_q);
    nchange_d  = ~((|chg) & ~nstable_q);
  end

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      prev_q    <= 2'b11;
      out_q     <= 2'b11;
      settled_q <= 2'b00;
      nstable_q <= 1'b1;
      nchange_q <= 1'b1;
      glitch_q  <= 8'd0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_INIT;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      prev_q    <= s2_q;
      out_q     <= out_d;
      settled_q <= settled_d;
      nstable_q <= nstable_d;
      nchange_q <= nchange_d;
      glitch_q  <= glitch_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign PWRSTAT   = out_q[0];
  assign MRST      = out_q[1];
  assign nSTABLE   = nstable_q;
  assign nCHANGE   = nchange_q;
  assign GLITCHCNT = glitch_q;

endmodule

// File: tb/tb_bubbledrive8_pwrmon.sv
// tb/tb_bubbledrive8_pwrmon.sv - directed bench for the power-status debouncer
// Inputs change 1 time unit after a rising edge, so the next edge is the capture edge (edge 1).
module tb_bubbledrive8_pwrmon;

  logic       MCLK;
  logic       nRST;
  logic       PWRSTAT_RAW;
  logic       MRST_RAW;
  logic       PWRSTAT;
  logic       MRST;
  logic       nSTABLE;
  logic       nCHANGE;
  logic [7:0] GLITCHCNT;

  int total;
  int bad;

  bubbledrive8_pwrmon #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (3)
  ) dut (
    .MCLK       (MCLK),
    .nRST       (nRST),
    .PWRSTAT_RAW(PWRSTAT_RAW),
    .MRST_RAW   (MRST_RAW),
    .PWRSTAT    (PWRSTAT),
    .MRST       (MRST),
    .nSTABLE    (nSTABLE),
    .nCHANGE    (nCHANGE),
    .GLITCHCNT  (GLITCHCNT)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic test_reset();
    nRST        = 1'b0;
    PWRSTAT_RAW = 1'b0;
    MRST_RAW    = 1'b0;
    repeat (3) tick();
    total++;
    if ({PWRSTAT, MRST, nSTABLE, nCHANGE} !== 4'b1111) begin
      bad++;
      $display("FAIL reset_flags got=%b want=1111", {PWRSTAT, MRST, nSTABLE, nCHANGE});
    end
    total++;
    if (GLITCHCNT !== 8'd0) begin
      bad++;
      $display("FAIL reset_glitchcnt got=%0d want=0", GLITCHCNT);
    end
  endtask

  // Release reset with both raws at 0 and follow acquisition edge by edge.
  task automatic test_acquire(input string tag);
    logic exp_out;
    logic exp_ns;
    nRST = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp_out = (e >= 6) ? 1'b0 : 1'b1;
      exp_ns  = (e >= 7) ? 1'b0 : 1'b1;
      total++;
      if ({PWRSTAT, MRST, nSTABLE, nCHANGE} !== {exp_out, exp_out, exp_ns, 1'b1}) begin
        bad++;
        $display("FAIL %s_edge%0d got=%b want=%b", tag, e,
                 {PWRSTAT, MRST, nSTABLE, nCHANGE}, {exp_out, exp_out, exp_ns, 1'b1});
      end
    end
  endtask

  task automatic test_mrst_rise();
    logic exp_m;
    logic exp_nc;
    MRST_RAW = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_m  = (e >= 6) ? 1'b1 : 1'b0;
      exp_nc = (e == 6) ? 1'b0 : 1'b1;
      total++;
      if ({PWRSTAT, MRST, nCHANGE} !== {1'b0, exp_m, exp_nc}) begin
        bad++;
        $display("FAIL mrst_rise_edge%0d got=%b want=%b", e, {PWRSTAT, MRST, nCHANGE},
                 {1'b0, exp_m, exp_nc});
      end
    end
    total++;
    if (GLITCHCNT !== 8'd0) begin
      bad++;
      $display("FAIL mrst_rise_glitchcnt got=%0d want=0", GLITCHCNT);
    end
  endtask

  task automatic test_glitch_reject();
    PWRSTAT_RAW = 1'b1;
    repeat (3) tick();
    PWRSTAT_RAW = 1'b0;
    for (int e = 4; e <= 9; e++) begin
      tick();
      total++;
      if ({PWRSTAT, nCHANGE} !== 2'b01) begin
        bad++;
        $display("FAIL glitch3_edge%0d got=%b want=01", e, {PWRSTAT, nCHANGE});
      end
    end
    total++;
    if (GLITCHCNT !== 8'd1) begin
      bad++;
      $display("FAIL glitch3_count got=%0d want=1", GLITCHCNT);
    end
  endtask

  task automatic test_pulse_accept();
    logic exp_p;
    logic exp_nc;
    PWRSTAT_RAW = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 4) PWRSTAT_RAW = 1'b0;
      exp_p  = (e >= 6 && e < 10) ? 1'b1 : 1'b0;
      exp_nc = (e == 6 || e == 10) ? 1'b0 : 1'b1;
      total++;
      if ({PWRSTAT, MRST, nCHANGE} !== {exp_p, 1'b1, exp_nc}) begin
        bad++;
        $display("FAIL pulse4_edge%0d got=%b want=%b", e, {PWRSTAT, MRST, nCHANGE},
                 {exp_p, 1'b1, exp_nc});
      end
    end
    total++;
    if (GLITCHCNT !== 8'd1) begin
      bad++;
      $display("FAIL pulse4_glitchcnt got=%0d want=1", GLITCHCNT);
    end
  endtask

  task automatic test_both_change();
    logic [1:0] exp_pm;
    logic       exp_nc;
    PWRSTAT_RAW = 1'b1;
    MRST_RAW    = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_pm = (e >= 6) ? 2'b10 : 2'b01;
      exp_nc = (e == 6) ? 1'b0 : 1'b1;
      total++;
      if ({PWRSTAT, MRST, nCHANGE} !== {exp_pm, exp_nc}) begin
        bad++;
        $display("FAIL both_edge%0d got=%b want=%b", e, {PWRSTAT, MRST, nCHANGE},
                 {exp_pm, exp_nc});
      end
    end
  endtask

  task automatic test_both_glitch();
    PWRSTAT_RAW = 1'b0;
    MRST_RAW    = 1'b1;
    tick();
    PWRSTAT_RAW = 1'b1;
    MRST_RAW    = 1'b0;
    repeat (6) tick();
    total++;
    if (GLITCHCNT !== 8'd3) begin
      bad++;
      $display("FAIL both_glitch_count got=%0d want=3", GLITCHCNT);
    end
    total++;
    if ({PWRSTAT, MRST, nCHANGE} !== 3'b101) begin
      bad++;
      $display("FAIL both_glitch_outputs got=%b want=101", {PWRSTAT, MRST, nCHANGE});
    end
  endtask

  task automatic glitch_burst(input int n);
    for (int k = 0; k < n; k++) begin
      PWRSTAT_RAW = 1'b0;
      tick();
      PWRSTAT_RAW = 1'b1;
      tick();
    end
    repeat (5) tick();
  endtask

  task automatic test_saturate();
    glitch_burst(100);
    total++;
    if (GLITCHCNT !== 8'd103) begin
      bad++;
      $display("FAIL sat_mid_count got=%0d want=103", GLITCHCNT);
    end
    glitch_burst(200);
    total++;
    if (GLITCHCNT !== 8'd255) begin
      bad++;
      $display("FAIL sat_count got=%0d want=255", GLITCHCNT);
    end
    total++;
    if ({PWRSTAT, MRST, nSTABLE, nCHANGE} !== 4'b1001) begin
      bad++;
      $display("FAIL sat_outputs got=%b want=1001", {PWRSTAT, MRST, nSTABLE, nCHANGE});
    end
  endtask

  task automatic test_reset_mid_count();
    PWRSTAT_RAW = 1'b0;
    repeat (4) tick();
    nRST = 1'b0;
    #2;
    total++;
    if ({PWRSTAT, MRST, nSTABLE, nCHANGE} !== 4'b1111) begin
      bad++;
      $display("FAIL midreset_flags got=%b want=1111", {PWRSTAT, MRST, nSTABLE, nCHANGE});
    end
    total++;
    if (GLITCHCNT !== 8'd0) begin
      bad++;
      $display("FAIL midreset_glitchcnt got=%0d want=0", GLITCHCNT);
    end
    MRST_RAW = 1'b0;
    tick();
    test_acquire("reacquire");
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    nRST        = 1'b0;
    PWRSTAT_RAW = 1'b0;
    MRST_RAW    = 1'b0;
    test_reset();
    test_acquire("acquire");
    test_mrst_rise();
    test_glitch_reject();
    test_pulse_accept();
    test_both_change();
    test_both_glitch();
    test_saturate();
    test_reset_mid_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
